universal_register: RTL and testbench

Parametrised successor to the team's 3-bit enabled register. It is a single WIDTH-bit storage register with an asynchronous active-low reset and a clock-enable. It adds a synchronous clear and eight operating modes: hold, parallel load, shift, rotate, increment and decrement. A registered carry/shift-out flag and a zero flag let it serve as a datapath accumulator, shift register or loop counter.

---
 rtl/universal_register.sv | 126 ++++++++++++
 tb/tb_universal_register.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/universal_register.sv
// universal_register
//   WIDTH-bit storage register with clock-enable and synchronous clear. It can
//   hold, load, shift, rotate, increment or decrement, so one block can act as
//   an accumulator, a shift register or a loop counter.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low; forces q to RESET_VALUE and clears carry
//   enable     clock enable; when low, q and carry hold
//   clear      synchronous clear; overrides enable and mode
//   mode       operation select (table below)
//   d          parallel load data
//   serial_in  fill bit for SHL / SHR
//   q          registered contents
//   carry      registered shift-out / wrap flag from the last enabled non-HOLD op
//   zero       combinational, high when q == 0
//
// mode | operation
// 000  | HOLD  q, carry unchanged
// 001  | LOAD  q <= d, carry <= 0
// 010  | SHL   q <= {q[W-2:0], serial_in}, carry <= q[W-1]
// 011  | SHR   q <= {serial_in, q[W-1:1]}, carry <= q[0]
// 100  | ROL   q <= {q[W-2:0], q[W-1]},    carry <= q[W-1]
// 101  | ROR   q <= {q[0], q[W-1:1]},      carry <= q[0]
// 110  | INC   q <= q + 1, carry <= wrap from all ones
// 111  | DEC   q <= q - 1, carry <= wrap from zero

module universal_register #(
   parameter int          WIDTH       = 8,
   parameter logic [63:0] RESET_VALUE = 64'd0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             carry,
   output logic             zero
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_INC  = 3'b110;
   localparam logic [2:0] MODE_DEC  = 3'b111;

   localparam logic [WIDTH-1:0] RESET_Q = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] q_nxt;
   logic             carry_nxt;

   // One extra bit on the arithmetic paths: bit WIDTH is the wrap indication
   // (carry out of INC, borrow out of DEC).
   logic [WIDTH:0] inc_sum;
   logic [WIDTH:0] dec_diff;

   assign inc_sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      q_nxt     = q;
      carry_nxt = carry;
      if (enable) begin
         case (mode)
            MODE_HOLD: begin
               q_nxt     = q;
               carry_nxt = carry;
            end
            MODE_LOAD: begin
               q_nxt     = d;
               carry_nxt = 1'b0;
            end
            MODE_SHL: begin
               q_nxt     = {q[WIDTH-2:0], serial_in};
               carry_nxt = q[WIDTH-1];
            end
            MODE_SHR: begin
               q_nxt     = {serial_in, q[WIDTH-1:1]};
               carry_nxt = q[0];
            end
            MODE_ROL: begin
               q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
               carry_nxt = q[WIDTH-1];
            end
            MODE_ROR: begin
               q_nxt     = {q[0], q[WIDTH-1:1]};
               carry_nxt = q[0];
            end
            MODE_INC: begin
               q_nxt     = inc_sum[WIDTH-1:0];
               carry_nxt = inc_sum[WIDTH];
            end
            MODE_DEC: begin
               q_nxt     = dec_diff[WIDTH-1:0];
               carry_nxt = dec_diff[WIDTH];
            end
            default: begin
               q_nxt     = q;
               carry_nxt = carry;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q     <= RESET_Q;
         carry <= 1'b0;
      end else if (clear) begin
         q     <= '0;
         carry <= 1'b0;
      end else begin
         q     <= q_nxt;
         carry <= carry_nxt;
      end
   end

   assign zero = (q == '0);

endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register
//   Directed bench for universal_register (WIDTH=8, RESET_VALUE=8'hA5).
//   Each scenario task drives inputs one tick at a time and compares q, carry
//   and zero against hand-computed values.

module tb_universal_register;

   localparam logic [2:0] HOLD = 3'b000;
   localparam logic [2:0] LOAD = 3'b001;
   localparam logic [2:0] SHL  = 3'b010;
   localparam logic [2:0] SHR  = 3'b011;
   localparam logic [2:0] ROL  = 3'b100;
   localparam logic [2:0] ROR  = 3'b101;
   localparam logic [2:0] INC  = 3'b110;
   localparam logic [2:0] DEC  = 3'b111;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       clear = 1'b0;
   logic [2:0] mode = HOLD;
   logic [7:0] d = 8'h00;
   logic       serial_in = 1'b0;
   logic [7:0] q;
   logic       carry;
   logic       zero;

   int total = 0;
   int bad   = 0;

   universal_register #(.WIDTH(8), .RESET_VALUE(64'hA5)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .clear     (clear),
      .mode      (mode),
      .d         (d),
      .serial_in (serial_in),
      .q         (q),
      .carry     (carry),
      .zero      (zero)
   );

   always #5 clock = ~clock;

   // Apply one operation and let it take effect; returns 1 time unit after the edge.
   task automatic op(input logic en, input logic [2:0] md, input logic [7:0] dv, input logic si);
      enable    = en;
      mode      = md;
      d         = dv;
      serial_in = si;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h want=a5", q); end
      total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry); end
      total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
      op(1'b1, LOAD, 8'h3C, 1'b0);
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL reset_hold_q got=%h want=a5", q); end
      reset = 1'b1;
   endtask

   task automatic test_load_hold();
      op(1'b1, LOAD, 8'h3C, 1'b0);
      total++; if (q !== 8'h3C || carry !== 1'b0) begin bad++; $display("FAIL load got=%h/%b want=3c/0", q, carry); end
      for (int i = 0; i < 3; i++) begin
         op(1'b0, INC, 8'h00, 1'b0);
         total++; if (q !== 8'h3C) begin bad++; $display("FAIL enable_off_%0d got=%h want=3c", i, q); end
      end
      op(1'b1, HOLD, 8'hFF, 1'b1);
      total++; if (q !== 8'h3C || carry !== 1'b0) begin bad++; $display("FAIL hold got=%h/%b want=3c/0", q, carry); end
   endtask

   task automatic test_shift_rotate();
      op(1'b1, LOAD, 8'h81, 1'b0);
      op(1'b1, SHL, 8'h00, 1'b0);
      total++; if (q !== 8'h02 || carry !== 1'b1) begin bad++; $display("FAIL shl got=%h/%b want=02/1", q, carry); end
      op(1'b1, LOAD, 8'h81, 1'b0);
      total++; if (carry !== 1'b0) begin bad++; $display("FAIL load_clears_carry got=%b want=0", carry); end
      op(1'b1, SHR, 8'h00, 1'b1);
      total++; if (q !== 8'hC0 || carry !== 1'b1) begin bad++; $display("FAIL shr got=%h/%b want=c0/1", q, carry); end
      op(1'b1, LOAD, 8'h81, 1'b0);
      op(1'b1, ROL, 8'h00, 1'b0);
      total++; if (q !== 8'h03 || carry !== 1'b1) begin bad++; $display("FAIL rol got=%h/%b want=03/1", q, carry); end
      op(1'b1, LOAD, 8'h81, 1'b0);
      op(1'b1, ROR, 8'h00, 1'b0);
      total++; if (q !== 8'hC0 || carry !== 1'b1) begin bad++; $display("FAIL ror got=%h/%b want=c0/1", q, carry); end
      op(1'b1, LOAD, 8'h40, 1'b0);
      op(1'b1, SHL, 8'h00, 1'b1);
      total++; if (q !== 8'h81 || carry !== 1'b0) begin bad++; $display("FAIL shl_fill1 got=%h/%b want=81/0", q, carry); end
      op(1'b1, LOAD, 8'h02, 1'b0);
      op(1'b1, SHR, 8'h00, 1'b0);
      total++; if (q !== 8'h01 || carry !== 1'b0) begin bad++; $display("FAIL shr_fill0 got=%h/%b want=01/0", q, carry); end
      op(1'b1, LOAD, 8'h42, 1'b0);
      op(1'b1, ROL, 8'h00, 1'b1);
      total++; if (q !== 8'h84 || carry !== 1'b0) begin bad++; $display("FAIL rol_nocarry got=%h/%b want=84/0", q, carry); end
      op(1'b1, ROR, 8'h00, 1'b1);
      total++; if (q !== 8'h42 || carry !== 1'b0) begin bad++; $display("FAIL ror_nocarry got=%h/%b want=42/0", q, carry); end
   endtask

   task automatic test_wrap();
      op(1'b1, LOAD, 8'hFE, 1'b0);
      op(1'b1, INC, 8'h00, 1'b0);
      total++; if (q !== 8'hFF || carry !== 1'b0) begin bad++; $display("FAIL inc_ff got=%h/%b want=ff/0", q, carry); end
      op(1'b1, INC, 8'h00, 1'b0);
      total++; if (q !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin bad++; $display("FAIL inc_wrap got=%h/%b/%b want=00/1/1", q, carry, zero); end
      op(1'b0, DEC, 8'h00, 1'b0);
      total++; if (q !== 8'h00 || carry !== 1'b1) begin bad++; $display("FAIL carry_hold got=%h/%b want=00/1", q, carry); end
      op(1'b1, HOLD, 8'h00, 1'b0);
      total++; if (carry !== 1'b1) begin bad++; $display("FAIL hold_carry got=%b want=1", carry); end
      op(1'b1, DEC, 8'h00, 1'b0);
      total++; if (q !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin bad++; $display("FAIL dec_wrap got=%h/%b/%b want=ff/1/0", q, carry, zero); end
      op(1'b1, DEC, 8'h00, 1'b0);
      total++; if (q !== 8'hFE || carry !== 1'b0) begin bad++; $display("FAIL dec_fe got=%h/%b want=fe/0", q, carry); end
   endtask

   task automatic test_priority();
      op(1'b1, LOAD, 8'h55, 1'b0);
      clear = 1'b1;
      op(1'b1, LOAD, 8'hAA, 1'b0);
      clear = 1'b0;
      total++; if (q !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin bad++; $display("FAIL clear_en got=%h/%b/%b want=00/0/1", q, carry, zero); end
      op(1'b1, LOAD, 8'h81, 1'b0);
      op(1'b1, SHL, 8'h00, 1'b0);
      clear = 1'b1;
      op(1'b0, INC, 8'h00, 1'b0);
      clear = 1'b0;
      total++; if (q !== 8'h00 || carry !== 1'b0) begin bad++; $display("FAIL clear_noen got=%h/%b want=00/0", q, carry); end
   endtask

   task automatic test_reset_mid();
      op(1'b1, LOAD, 8'h10, 1'b0);
      for (int i = 0; i < 5; i++) op(1'b1, INC, 8'h00, 1'b0);
      total++; if (q !== 8'h15) begin bad++; $display("FAIL inc_run got=%h want=15", q); end
      reset = 1'b0;
      #1;
      total++; if (q !== 8'hA5 || carry !== 1'b0) begin bad++; $display("FAIL reset_mid got=%h/%b want=a5/0", q, carry); end
      reset = 1'b1;
      op(1'b1, INC, 8'h00, 1'b0);
      total++; if (q !== 8'hA6 || carry !== 1'b0) begin bad++; $display("FAIL inc_after_reset got=%h/%b want=a6/0", q, carry); end
   endtask

   task automatic test_back_to_back();
      op(1'b1, LOAD, 8'h0F, 1'b0);
      op(1'b1, INC, 8'h00, 1'b0);
      total++; if (q !== 8'h10) begin bad++; $display("FAIL b2b_inc got=%h want=10", q); end
      op(1'b1, SHL, 8'h00, 1'b1);
      total++; if (q !== 8'h21 || carry !== 1'b0) begin bad++; $display("FAIL b2b_shl got=%h/%b want=21/0", q, carry); end
      op(1'b1, ROR, 8'h00, 1'b0);
      total++; if (q !== 8'h90 || carry !== 1'b1) begin bad++; $display("FAIL b2b_ror got=%h/%b want=90/1", q, carry); end
      op(1'b1, DEC, 8'h00, 1'b0);
      total++; if (q !== 8'h8F || carry !== 1'b0) begin bad++; $display("FAIL b2b_dec got=%h/%b want=8f/0", q, carry); end
   endtask

   initial begin
      test_reset();
      test_load_hold();
      test_shift_rotate();
      test_wrap();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
